// File: rtl/systolic_pkg.sv
// Shared types and elaboration-time helpers for the systolic array sequencer.
//   state_e  : 2-bit controller state encoding (idle / load / compute / done)
//   clog2    : ceil(log2(v)), never below 1 so that K_SIZE = 1 still gets a legal index width
//   calc_l   : LOAD operand count L = max(H*K, K*W)
//   calc_c   : COMPUTE length C = K + H + W - 2 + PE_LAT
// Derived widths used by the other files: AW = clog2(L), KW = clog2(K_SIZE).
package systolic_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLoad    = 2'd1,
    StCompute = 2'd2,
    StDone    = 2'd3
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned calc_l(input int unsigned h, input int unsigned w,
                                         input int unsigned k);
    return (h * k > k * w) ? h * k : k * w;
  endfunction

  function automatic int unsigned calc_c(input int unsigned h, input int unsigned w,
                                         input int unsigned k, input int unsigned lat);
    return k + h + w - 2 + lat;
  endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Host / array-edge signal bundle for systolic_ctrl.
//   master : controller side (samples data_valid, drives everything else)
//   slave  : host / array side
// Signals: data_valid, read_data, buf_wr_en_a/b, buf_wr_addr[AW], start_compute,
//          row_feed_en[HEIGHT], row_k[HEIGHT*KW], col_feed_en[WIDTH], col_k[WIDTH*KW],
//          busy, done, and perf_cycles[16] when SYSTOLIC_CTRL_PERF_EN is defined.
interface systolic_ctrl_if #(
  parameter int unsigned HEIGHT = 4,
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned K_SIZE = 4
);
  localparam int unsigned AW = systolic_pkg::clog2(systolic_pkg::calc_l(HEIGHT, WIDTH, K_SIZE));
  localparam int unsigned KW = systolic_pkg::clog2(K_SIZE);

  logic                   data_valid;
  logic                   read_data;
  logic                   buf_wr_en_a;
  logic                   buf_wr_en_b;
  logic [AW-1:0]          buf_wr_addr;
  logic                   start_compute;
  logic [HEIGHT-1:0]      row_feed_en;
  logic [HEIGHT*KW-1:0]   row_k;
  logic [WIDTH-1:0]       col_feed_en;
  logic [WIDTH*KW-1:0]    col_k;
  logic                   busy;
  logic                   done;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [15:0]            perf_cycles;
`endif

  modport master (
    input  data_valid,
    output read_data, buf_wr_en_a, buf_wr_en_b, buf_wr_addr, start_compute,
           row_feed_en, row_k, col_feed_en, col_k, busy, done
`ifdef SYSTOLIC_CTRL_PERF_EN
    , output perf_cycles
`endif
  );

  modport slave (
    output data_valid,
    input  read_data, buf_wr_en_a, buf_wr_en_b, buf_wr_addr, start_compute,
           row_feed_en, row_k, col_feed_en, col_k, busy, done
`ifdef SYSTOLIC_CTRL_PERF_EN
    , input perf_cycles
`endif
  );

endinterface

// File: rtl/systolic_skew_gen.sv
// Skewed feed generator for one array edge.
// Lane i is enabled while i <= t < i + K_SIZE and then carries k index t - i; idle lanes
// drive index 0.
//   active  in  1       controller is in COMPUTE
//   t       in  TW      compute cycle counter
//   feed_en out N       per-lane injection enable
//   k_idx   out N*KW    packed per-lane k index (lane i at [i*KW +: KW])
module systolic_skew_gen #(
  parameter int unsigned N      = 4,
  parameter int unsigned K_SIZE = 4,
  parameter int unsigned TW     = 4,
  parameter int unsigned KW     = 2
) (
  input  logic            active,
  input  logic [TW-1:0]   t,
  output logic [N-1:0]    feed_en,
  output logic [N*KW-1:0] k_idx
);

  always_comb begin
    feed_en = '0;
    k_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (active && (32'(t) >= i) && (32'(t) < i + K_SIZE)) begin
        feed_en[i]         = 1'b1;
        k_idx[i*KW +: KW]  = KW'(32'(t) - i);
      end
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for a HEIGHT x WIDTH systolic matmul array (C = A[HxK] * B[KxW]).
// On an accepted start it streams L = max(H*K, K*W) operand pairs from the host into the A/B
// edge buffers, then runs C = K+H+W-2+PE_LAT compute cycles of skewed edge feeds, then holds
// done until the next start.
// Ports: clk, rst_n (async, active low), bus (systolic_ctrl_if.master, see interface file).
// Optional: define SYSTOLIC_CTRL_PERF_EN to add the 16-bit saturating bus.perf_cycles counter
// (cleared on acceptance, counts LOAD/COMPUTE cycles, holds otherwise).
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned HEIGHT = 4,
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned K_SIZE = 4,
  parameter int unsigned PE_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  systolic_ctrl_if.master bus
);

  localparam int unsigned L   = calc_l(HEIGHT, WIDTH, K_SIZE);
  localparam int unsigned C   = calc_c(HEIGHT, WIDTH, K_SIZE, PE_LAT);
  localparam int unsigned AW  = clog2(L);
  localparam int unsigned KW  = clog2(K_SIZE);
  localparam int unsigned NW  = clog2(L + 1);  // n must be able to hold L itself
  localparam int unsigned TW  = clog2(C);
  localparam int unsigned HK  = HEIGHT * K_SIZE;
  localparam int unsigned KWN = K_SIZE * WIDTH;

  state_e        state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [TW-1:0] t_q, t_d;
  logic          accept;
  logic          compute_active;
  logic          wr_active;
  logic [NW-1:0] wr_idx;

  assign accept = ((state_q == StIdle) || (state_q == StDone)) && bus.data_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      n_q     <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      t_q     <= t_d;
    end
  end

  // Counters stop at their terminal value; the state change is what ends each phase.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    t_d     = t_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = StLoad;
          n_d     = '0;
          t_d     = '0;
        end
      end
      StLoad: begin
        if (n_q == NW'(L)) begin
          state_d = StCompute;
          t_d     = '0;
        end else begin
          n_d = n_q + NW'(1);
        end
      end
      StCompute: begin
        if (t_q == TW'(C - 1)) begin
          state_d = StDone;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Host data arrives one cycle after read_data, so the write for element n happens at n+1.
  assign wr_active = (state_q == StLoad) && (n_q != '0);
  assign wr_idx    = n_q - NW'(1);

  assign bus.read_data     = (state_q == StLoad) && (n_q < NW'(L));
  assign bus.buf_wr_en_a   = wr_active && (wr_idx < NW'(HK));
  assign bus.buf_wr_en_b   = wr_active && (wr_idx < NW'(KWN));
  assign bus.buf_wr_addr   = wr_active ? wr_idx[AW-1:0] : '0;
  assign compute_active    = (state_q == StCompute);
  assign bus.start_compute = compute_active && (t_q == '0);
  assign bus.busy          = (state_q == StLoad) || compute_active;
  assign bus.done          = (state_q == StDone);

  systolic_skew_gen #(
    .N      (HEIGHT),
    .K_SIZE (K_SIZE),
    .TW     (TW),
    .KW     (KW)
  ) u_row_skew (
    .active  (compute_active),
    .t       (t_q),
    .feed_en (bus.row_feed_en),
    .k_idx   (bus.row_k)
  );

  systolic_skew_gen #(
    .N      (WIDTH),
    .K_SIZE (K_SIZE),
    .TW     (TW),
    .KW     (KW)
  ) u_col_skew (
    .active  (compute_active),
    .t       (t_q),
    .feed_en (bus.col_feed_en),
    .k_idx   (bus.col_k)
  );

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (accept) begin
      perf_d = '0;
    end else if (bus.busy && (perf_q != 16'hFFFF)) begin
      perf_d = perf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign bus.perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: a 4x4x4 instance checked cycle by cycle against a
// timing model, plus a 2x3x4 instance checked through a write-address scoreboard.
module tb_systolic_ctrl;

  localparam int H   = 4;
  localparam int W   = 4;
  localparam int K   = 4;
  localparam int L   = 16;  // max(H*K, K*W)
  localparam int C   = 11;  // K+H+W-2+PE_LAT
  localparam int AW  = 4;
  localparam int KW  = 2;
  localparam int H2  = 2;
  localparam int W2  = 3;
  localparam int K2  = 4;
  localparam int L2  = 12;
  localparam int C2  = 8;
  localparam int AW2 = 4;

  typedef struct packed {
    logic            rd;
    logic            wa;
    logic            wb;
    logic [AW-1:0]   addr;
    logic            sc;
    logic [H-1:0]    ren;
    logic [H*KW-1:0] rk;
    logic [W-1:0]    cen;
    logic [W*KW-1:0] ck;
    logic            busy;
    logic            done;
  } obs_t;

  typedef struct packed {
    logic           wa;
    logic           wb;
    logic [AW2-1:0] addr;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  obs_t exp_q[$];
  wr_t  wr_q[$];

  always #5 clk = ~clk;

  systolic_ctrl_if #(.HEIGHT(H), .WIDTH(W), .K_SIZE(K)) bus ();
  systolic_ctrl_if #(.HEIGHT(H2), .WIDTH(W2), .K_SIZE(K2)) bus2 ();

  systolic_ctrl #(.HEIGHT(H), .WIDTH(W), .K_SIZE(K), .PE_LAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  systolic_ctrl #(.HEIGHT(H2), .WIDTH(W2), .K_SIZE(K2), .PE_LAT(1)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  task automatic chk(input string tag, input int cyc, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [63:0] pad(input obs_t o);
    return {{(64 - $bits(obs_t)){1'b0}}, o};
  endfunction

  // Expected outputs j cycles after the accepting edge (j = 1 is the first LOAD cycle).
  function automatic obs_t model(input int j);
    obs_t e;
    int   t;
    e = '0;
    e.rd = (j >= 1) && (j <= L);
    if ((j >= 2) && (j <= L + 1)) begin
      e.wa   = (j - 2) < H * K;
      e.wb   = (j - 2) < K * W;
      e.addr = AW'(j - 2);
    end
    e.sc = (j == L + 2);
    if ((j >= L + 2) && (j <= L + 1 + C)) begin
      t = j - (L + 2);
      for (int r = 0; r < H; r++) begin
        if ((t >= r) && (t < r + K)) begin
          e.ren[r] = 1'b1;
          e.rk[r*KW +: KW] = KW'(t - r);
        end
      end
      for (int c = 0; c < W; c++) begin
        if ((t >= c) && (t < c + K)) begin
          e.cen[c] = 1'b1;
          e.ck[c*KW +: KW] = KW'(t - c);
        end
      end
    end
    e.busy = (j >= 1) && (j <= L + 1 + C);
    e.done = (j >= L + 2 + C);
    return e;
  endfunction

  function automatic obs_t sample1();
    obs_t o;
    o.rd   = bus.read_data;
    o.wa   = bus.buf_wr_en_a;
    o.wb   = bus.buf_wr_en_b;
    o.addr = bus.buf_wr_addr;
    o.sc   = bus.start_compute;
    o.ren  = bus.row_feed_en;
    o.rk   = bus.row_k;
    o.cen  = bus.col_feed_en;
    o.ck   = bus.col_k;
    o.busy = bus.busy;
    o.done = bus.done;
    return o;
  endfunction

  task automatic push_job(input int n);
    for (int j = 1; j <= n; j++) exp_q.push_back(model(j));
  endtask

  // Caller leaves data_valid high for the accepting edge; pa/pb are extra pulse cycles.
  task automatic run_job(input int last, input int pa, input int pb, input string tag);
    obs_t e;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      #1;
      bus.data_valid = (c == pa) || (c == pb);
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = '1;
      chk(tag, c, pad(sample1()), pad(e));
    end
  endtask

  initial begin
    int  done_cyc;
    int  wr_seen;
    wr_t w;
    wr_t got;

    bus.data_valid  = 1'b0;
    bus2.data_valid = 1'b0;

    repeat (3) begin
      @(posedge clk);
      #1;
      chk("reset", 0, pad(sample1()), pad(model(0)));
      chk("reset2", 0, {61'd0, bus2.read_data, bus2.busy, bus2.done}, 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle", 0, pad(sample1()), pad(model(0)));

    // Plain job: load timing, skew, done.
    bus.data_valid = 1'b1;
    push_job(L + C + 2);
    run_job(L + C + 2, -1, -1, "jobA");

    // Restart from DONE, with pulses during LOAD and COMPUTE that must be ignored.
    bus.data_valid = 1'b1;
    push_job(L + C + 3);
    run_job(L + C + 3, 10, 22, "jobB");

    // Back-to-back from DONE, aborted by reset part way through COMPUTE.
    bus.data_valid = 1'b1;
    push_job(20);
    run_job(20, -1, -1, "jobC");
    rst_n = 1'b0;
    #1;
    chk("async_reset", 20, pad(sample1()), pad(model(0)));
    @(posedge clk);
    #1;
    chk("reset_hold", 21, pad(sample1()), pad(model(0)));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_idle", 0, pad(sample1()), pad(model(0)));

    bus.data_valid = 1'b1;
    push_job(L + C + 2);
    run_job(L + C + 2, -1, -1, "jobD");

    // Non-square instance: write strobes through a scoreboard, done timing, perf count.
    for (int n = 0; n < L2; n++) begin
      w.wa   = (n < H2 * K2);
      w.wb   = (n < K2 * W2);
      w.addr = AW2'(n);
      wr_q.push_back(w);
    end
    done_cyc = -1;
    wr_seen  = 0;
    bus2.data_valid = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      bus2.data_valid = 1'b0;
      if (bus2.buf_wr_en_a || bus2.buf_wr_en_b) begin
        wr_seen++;
        got.wa   = bus2.buf_wr_en_a;
        got.wb   = bus2.buf_wr_en_b;
        got.addr = bus2.buf_wr_addr;
        if (wr_q.size() != 0) begin
          w = wr_q.pop_front();
          chk("dut2_wr", c, 64'(got), 64'(w));
        end
      end
      if (bus2.done && (done_cyc < 0)) done_cyc = c;
    end
    chk("dut2_wr_count", -1, 64'(wr_seen), 64'(L2));
    chk("dut2_done_cyc", -1, 64'(done_cyc), 64'(L2 + C2 + 2));
    chk("dut2_done_hold", 30, {63'd0, bus2.done}, 64'd1);
`ifdef SYSTOLIC_CTRL_PERF_EN
    chk("dut2_perf", 30, {48'd0, bus2.perf_cycles}, 64'd21);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
